// File: rtl/sr_reg_bank.sv
// Bank of independent set/reset bits with selectable s=r=1 resolution,
// optional rising-edge request detection, parallel load and conflict status.
module sr_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned EDGE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_conf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] conf_sticky,
  output logic [CNT_W-1:0] conf_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] s_prev_q, r_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] se, re, conf;

  // Outcome of a simultaneous set and reset; unknown modes fall back to hold.
  function automatic logic resolve_both(input logic cur);
    if (MODE == 0)      return 1'b0;
    else if (MODE == 1) return 1'b1;
    else if (MODE == 2) return ~cur;
    else                return cur;
  endfunction

  // Effective requests: raw levels, or rising edges against last cycle's inputs.
  always_comb begin
    if (EDGE == 1) begin
      se = s & ~s_prev_q;
      re = r & ~r_prev_q;
    end else begin
      se = s;
      re = r;
    end
  end

  assign conf = en & se & re & {WIDTH{~load}};

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (en[i]) begin
          case ({se[i], re[i]})
            2'b01:   q_d[i] = 1'b0;
            2'b10:   q_d[i] = 1'b1;
            2'b11:   q_d[i] = resolve_both(q_q[i]);
            default: q_d[i] = q_q[i];
          endcase
        end
      end
    end
  end

  // A fresh conflict outranks a coincident clear.
  always_comb begin
    sticky_d = (clr_conf ? '0 : sticky_q) | conf;
    cnt_d    = cnt_q;
    if (clr_conf) begin
      cnt_d = (|conf) ? CNT_W'(1) : '0;
    end else if (|conf && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      s_prev_q <= '0;
      r_prev_q <= '0;
    end else begin
      q_q      <= q_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      s_prev_q <= s;
      r_prev_q <= r;
    end
  end

  assign q           = q_q;
  assign conf_sticky = sticky_q;
  assign conf_cnt    = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: four level-sensitive banks (one per MODE, CNT_W=2) share
// stimulus; a separate rising-edge bank covers EDGE=1 behaviour.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s, r, en, d;
  logic       load, clr;
  logic [3:0] q_m [4];
  logic [3:0] st_m [4];
  logic [1:0] cnt_m [4];

  logic [3:0] s_e, r_e, en_e, d_e;
  logic       load_e, clr_e;
  logic [3:0] q_e, st_e;
  logic [7:0] cnt_e;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_reg_bank #(.WIDTH(4), .MODE(g), .EDGE(0), .CNT_W(2)) u_dut (
      .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .load(load), .d(d),
      .clr_conf(clr), .q(q_m[g]), .conf_sticky(st_m[g]), .conf_cnt(cnt_m[g])
    );
  end

  sr_reg_bank #(.WIDTH(4), .MODE(0), .EDGE(1), .CNT_W(8)) u_edge (
    .clk(clk), .rst(rst), .s(s_e), .r(r_e), .en(en_e), .load(load_e), .d(d_e),
    .clr_conf(clr_e), .q(q_e), .conf_sticky(st_e), .conf_cnt(cnt_e)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s = '0; r = '0; en = '0; d = '0; load = 1'b0; clr = 1'b0;
    s_e = '0; r_e = '0; en_e = '0; d_e = '0; load_e = 1'b0; clr_e = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== 4'h0 || st_m[k] !== 4'h0 || cnt_m[k] !== 2'd0) begin
        failures++;
        $display("FAIL reset_m%0d: got q=%b st=%b cnt=%0d expected 0/0/0", k, q_m[k], st_m[k], cnt_m[k]);
      end
    end
    checks++;
    if (q_e !== 4'h0 || st_e !== 4'h0 || cnt_e !== 8'd0) begin
      failures++;
      $display("FAIL reset_edge: got q=%b st=%b cnt=%0d expected 0/0/0", q_e, st_e, cnt_e);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_q [3];
    logic [3:0] s_v [3];
    logic [3:0] r_v [3];
    s_v = '{4'b0101, 4'b0000, 4'b0000};
    r_v = '{4'b0000, 4'b0001, 4'b0000};
    exp_q = '{4'b0101, 4'b0100, 4'b0100};
    en = 4'hF;
    for (int v = 0; v < 3; v++) begin
      s = s_v[v]; r = r_v[v];
      step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q_m[k] !== exp_q[v]) begin
          failures++;
          $display("FAIL basic_v%0d_m%0d: got q=%b expected %b", v, k, q_m[k], exp_q[v]);
        end
      end
    end
    checks++;
    if (cnt_m[0] !== 2'd0 || st_m[0] !== 4'h0) begin
      failures++;
      $display("FAIL basic_noconf: got cnt=%0d st=%b expected 0/0000", cnt_m[0], st_m[0]);
    end
  endtask

  task automatic test_modes();
    logic [3:0] exp1 [4];
    logic [3:0] exp2 [4];
    exp1 = '{4'b0000, 4'b1111, 4'b1100, 4'b0011};
    exp2 = '{4'b0000, 4'b1111, 4'b0011, 4'b0011};
    s = '0; r = '0; load = 1'b1; d = 4'b0011;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== 4'b0011 || cnt_m[k] !== 2'd0) begin
        failures++;
        $display("FAIL preload_m%0d: got q=%b cnt=%0d expected 0011/0", k, q_m[k], cnt_m[k]);
      end
    end
    load = 1'b0; s = 4'hF; r = 4'hF;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== exp1[k] || cnt_m[k] !== 2'd1 || st_m[k] !== 4'hF) begin
        failures++;
        $display("FAIL mode11_c1_m%0d: got q=%b cnt=%0d st=%b expected %b/1/1111", k, q_m[k], cnt_m[k], st_m[k], exp1[k]);
      end
    end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== exp2[k] || cnt_m[k] !== 2'd2 || st_m[k] !== 4'hF) begin
        failures++;
        $display("FAIL mode11_c2_m%0d: got q=%b cnt=%0d st=%b expected %b/2/1111", k, q_m[k], cnt_m[k], st_m[k], exp2[k]);
      end
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; d = 4'b1010; s = 4'hF; r = 4'hF; en = 4'hF;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== 4'b1010 || cnt_m[k] !== 2'd2 || st_m[k] !== 4'hF) begin
        failures++;
        $display("FAIL load_prio_m%0d: got q=%b cnt=%0d st=%b expected 1010/2/1111", k, q_m[k], cnt_m[k], st_m[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s = '0; r = '0; clr = 1'b1;
    step();
    checks++;
    if (cnt_m[0] !== 2'd0 || st_m[0] !== 4'h0) begin
      failures++;
      $display("FAIL clr_idle: got cnt=%0d st=%b expected 0/0000", cnt_m[0], st_m[0]);
    end
    clr = 1'b0; s = 4'hF; r = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (cnt_m[0] !== exp_cnt[c]) begin
        failures++;
        $display("FAIL sat_c%0d: got cnt=%0d expected %0d", c, cnt_m[0], exp_cnt[c]);
      end
    end
    clr = 1'b1;
    step();
    checks++;
    if (cnt_m[0] !== 2'd1 || st_m[0] !== 4'hF) begin
      failures++;
      $display("FAIL clr_with_conf: got cnt=%0d st=%b expected 1/1111", cnt_m[0], st_m[0]);
    end
    s = '0; r = '0;
    step();
    checks++;
    if (cnt_m[0] !== 2'd0 || st_m[0] !== 4'h0) begin
      failures++;
      $display("FAIL clr_alone: got cnt=%0d st=%b expected 0/0000", cnt_m[0], st_m[0]);
    end
    clr = 1'b0; en = 4'b0010; s = 4'hF; r = 4'hF;
    step();
    checks++;
    if (cnt_m[0] !== 2'd1 || st_m[0] !== 4'b0010) begin
      failures++;
      $display("FAIL en_mask_conf: got cnt=%0d st=%b expected 1/0010", cnt_m[0], st_m[0]);
    end
    s = '0; r = '0; en = 4'hF;
  endtask

  task automatic test_edge();
    logic [3:0] s_v [9];
    logic [3:0] r_v [9];
    logic [3:0] exp_q [9];
    s_v   = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    r_v   = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    exp_q = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    en_e = 4'hF;
    for (int v = 0; v < 9; v++) begin
      s_e = s_v[v]; r_e = r_v[v];
      step();
      checks++;
      if (q_e !== exp_q[v]) begin
        failures++;
        $display("FAIL edge_v%0d: got q=%b expected %b", v, q_e, exp_q[v]);
      end
    end
    s_e = '0; r_e = '0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 4'hF;
    step();
    load = 1'b0; s = 4'hF; r = 4'hF; en = 4'hF;
    repeat (3) step();
    checks++;
    if (q_m[1] !== 4'hF || cnt_m[1] !== 2'd3) begin
      failures++;
      $display("FAIL pre_async: got q=%b cnt=%0d expected 1111/3", q_m[1], cnt_m[1]);
    end
    s = '0; r = '0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    s_e = 4'b0001;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_m[k] !== 4'h0 || cnt_m[k] !== 2'd0 || st_m[k] !== 4'h0) begin
        failures++;
        $display("FAIL async_rst_m%0d: got q=%b cnt=%0d st=%b expected 0/0/0", k, q_m[k], cnt_m[k], st_m[k]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (q_e !== 4'b0001) begin
      failures++;
      $display("FAIL edge_after_rst: got q=%b expected 0001", q_e);
    end
    checks++;
    if (q_m[0] !== 4'h0 || cnt_m[0] !== 2'd0) begin
      failures++;
      $display("FAIL idle_after_rst: got q=%b cnt=%0d expected 0/0", q_m[0], cnt_m[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_load_priority();
    test_saturation();
    test_edge();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
